// File: rtl/block_ram_sdp.sv
// ---------------------------------------------------------------------------
// block_ram_sdp
//   Simple-dual-port block RAM (one write port, one read port, one clock)
//   with per-byte write enables, 1- or 2-cycle read latency with a valid
//   strobe, selectable read-during-write behaviour and an optional
//   hardware fill of every word after reset.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous, active-low reset (the array itself is not reset)
//   wr_en      write request
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   rd_en      read request
//   rd_addr    read address
//   rd_data    read data, holds its last value between completed reads
//   rd_valid   one-cycle pulse per completed read
//   init_busy  high while the fill runs; user accesses are ignored then
// ---------------------------------------------------------------------------
module block_ram_sdp #(
    parameter int                   RAM_WIDTH     = 8,
    parameter int                   RAM_ADDR_BITS = 13,
    parameter int                   BYTE_WIDTH    = 8,
    parameter int                   READ_LATENCY  = 1,
    parameter int                   RDW_MODE      = 0,
    parameter int                   INIT_ON_RESET = 1,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [RAM_ADDR_BITS-1:0]          wr_addr,
    input  logic [RAM_WIDTH-1:0]              wr_data,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]   wr_be,
    input  logic                              rd_en,
    input  logic [RAM_ADDR_BITS-1:0]          rd_addr,
    output logic [RAM_WIDTH-1:0]              rd_data,
    output logic                              rd_valid,
    output logic                              init_busy
);

    localparam int                       NUM_BYTES = RAM_WIDTH / BYTE_WIDTH;
    localparam int                       DEPTH     = 2 ** RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("block_ram_sdp: READ_LATENCY must be 1 or 2");
    end
    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("block_ram_sdp: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t                   r_state;
    logic [RAM_ADDR_BITS-1:0] r_fill_cnt;
    logic                     r_init_busy;

    logic [RAM_WIDTH-1:0]     r_mem [DEPTH];

    logic                     w_idle;
    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic [RAM_ADDR_BITS-1:0] w_mem_waddr;
    logic [RAM_WIDTH-1:0]     w_mem_wdata;
    logic [NUM_BYTES-1:0]     w_mem_we;
    logic [RAM_WIDTH-1:0]     w_rd_word;

    logic [RAM_WIDTH-1:0]     r_rd_q1;
    logic                     r_vld1;

    // Fill sequencer: the terminal compare on LAST_ADDR ends the fill, so
    // the counter wrapping to zero afterwards never re-enters INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            r_fill_cnt  <= '0;
            r_init_busy <= (INIT_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_fill_cnt <= r_fill_cnt + RAM_ADDR_BITS'(1);
                    if (r_fill_cnt == LAST_ADDR) begin
                        r_state     <= ST_IDLE;
                        r_init_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign init_busy = r_init_busy;

    // Write port mux: the fill owns the array while INIT is active.
    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_wr_fire = w_idle && wr_en;
        w_rd_fire = w_idle && rd_en;
        if (!w_idle) begin
            w_mem_waddr = r_fill_cnt;
            w_mem_wdata = INIT_VALUE;
            w_mem_we    = '1;
        end else begin
            w_mem_waddr = wr_addr;
            w_mem_wdata = wr_data;
            w_mem_we    = w_wr_fire ? wr_be : '0;
        end
        // Keep the array untouched while reset is held.
        if (!rst_n) begin
            w_mem_we = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (w_mem_we[b]) begin
                r_mem[w_mem_waddr][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                    w_mem_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word, with the optional byte-merged bypass for a same-address
    // write in the same cycle (otherwise the pre-write word is returned).
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if (RDW_MODE == 1 && w_wr_fire && (wr_addr == rd_addr)) begin
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    w_rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] =
                        wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q1 <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_vld1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_q1 <= w_rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [RAM_WIDTH-1:0] r_rd_q2;
        logic                 r_vld2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_q2 <= '0;
                r_vld2  <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rd_q2 <= r_rd_q1;
                end
            end
        end

        assign rd_data  = r_rd_q2;
        assign rd_valid = r_vld2;
    end else begin : g_lat1
        assign rd_data  = r_rd_q1;
        assign rd_valid = r_vld1;
    end

endmodule

// File: tb/tb_block_ram_sdp.sv
// ---------------------------------------------------------------------------
// tb_block_ram_sdp
//   Four block_ram_sdp instances share one stimulus stream, each with a
//   different (latency, read-during-write, fill) configuration. A memory
//   model per instance pushes expected read results, with their due cycle,
//   into a queue; an independent monitor pops and compares on each cycle.
// ---------------------------------------------------------------------------
module tb_block_ram_sdp;

    localparam int          W     = 32;
    localparam int          AB    = 4;
    localparam int          DEPTH = 16;
    localparam int          NB    = 4;
    localparam int          NI    = 4;
    localparam int          QD    = 64;
    localparam logic [31:0] INITV = 32'hA5A5A5A5;

    localparam int LAT [NI] = '{1, 2, 1, 2};
    localparam int RDW [NI] = '{0, 1, 1, 0};
    localparam int INI [NI] = '{1, 1, 0, 0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [NB-1:0] wr_be;
    logic          rd_en;
    logic [AB-1:0] rd_addr;

    logic [W-1:0]  rd_data_w   [NI];
    logic          rd_valid_w  [NI];
    logic          init_busy_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        block_ram_sdp #(
            .RAM_WIDTH    (W),
            .RAM_ADDR_BITS(AB),
            .BYTE_WIDTH   (8),
            .READ_LATENCY (LAT[g]),
            .RDW_MODE     (RDW[g]),
            .INIT_ON_RESET(INI[g]),
            .INIT_VALUE   (INITV)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_be    (wr_be),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data_w[g]),
            .rd_valid (rd_valid_w[g]),
            .init_busy(init_busy_w[g])
        );
    end

    // Reference state: word contents plus a mask of bits whose value is
    // known (an unfilled instance starts with undefined contents).
    logic [31:0] m_mem   [NI][DEPTH];
    logic [31:0] m_known [NI][DEPTH];
    logic [31:0] q_d     [NI][QD];
    logic [31:0] q_k     [NI][QD];
    int          q_due   [NI][QD];
    int          q_head  [NI];
    int          q_tail  [NI];
    int          busy_left [NI];
    logic [31:0] last_d  [NI];
    logic [31:0] last_k  [NI];
    int          cyc_n;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] be_mask(input logic [NB-1:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            q_head[i]    = 0;
            q_tail[i]    = 0;
            busy_left[i] = (INI[i] != 0) ? DEPTH : 0;
            last_d[i]    = '0;
            last_k[i]    = '1;
        end
    endtask

    // Applies one accepted clock edge to every instance's model.
    task automatic model_step();
        logic [31:0] exp_d, exp_k, bm;
        for (int i = 0; i < NI; i++) begin
            if (busy_left[i] > 0) begin
                busy_left[i]--;
                if (busy_left[i] == 0) begin
                    for (int a = 0; a < DEPTH; a++) begin
                        m_mem[i][a]   = INITV;
                        m_known[i][a] = '1;
                    end
                end
            end else begin
                bm = be_mask(wr_be);
                if (rd_en) begin
                    exp_d = m_mem[i][rd_addr];
                    exp_k = m_known[i][rd_addr];
                    if (RDW[i] == 1 && wr_en && wr_addr == rd_addr) begin
                        exp_d = (exp_d & ~bm) | (wr_data & bm);
                        exp_k = exp_k | bm;
                    end
                    q_d[i][q_tail[i] % QD]   = exp_d;
                    q_k[i][q_tail[i] % QD]   = exp_k;
                    q_due[i][q_tail[i] % QD] = cyc_n + LAT[i] - 1;
                    q_tail[i]++;
                end
                if (wr_en) begin
                    m_mem[i][wr_addr]   = (m_mem[i][wr_addr] & ~bm) | (wr_data & bm);
                    m_known[i][wr_addr] = m_known[i][wr_addr] | bm;
                end
            end
        end
    endtask

    // Every stimulus task starts and ends just after a falling edge.
    task automatic cyc(input logic we, input logic [AB-1:0] wa, input logic [W-1:0] wd,
                       input logic [NB-1:0] be, input logic re, input logic [AB-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        cyc_n++;
        if (rst_n) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares outputs every falling edge against the model.
    initial begin
        logic exp_v;
        int   h;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (init_busy_w[i] !== (busy_left[i] != 0)) begin
                    failures++;
                    $display("FAIL busy[%0d] cycle=%0d got=%0b exp=%0b", i, cyc_n,
                             init_busy_w[i], busy_left[i] != 0);
                end
                h     = q_head[i] % QD;
                exp_v = (q_head[i] != q_tail[i]) && (q_due[i][h] == cyc_n);
                checks++;
                if (rd_valid_w[i] !== exp_v) begin
                    failures++;
                    $display("FAIL valid[%0d] cycle=%0d got=%0b exp=%0b", i, cyc_n,
                             rd_valid_w[i], exp_v);
                end
                if (exp_v) begin
                    last_d[i] = q_d[i][h];
                    last_k[i] = q_k[i][h];
                    q_head[i]++;
                end
                checks++;
                if ((rd_data_w[i] & last_k[i]) !== (last_d[i] & last_k[i])) begin
                    failures++;
                    $display("FAIL data[%0d] cycle=%0d got=%h exp=%h mask=%h", i, cyc_n,
                             rd_data_w[i], last_d[i], last_k[i]);
                end
            end
        end
    end

    initial begin
        cyc_n   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[i][a]   = '0;
                m_known[i][a] = '0;
            end
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Write then read addr 15 right after release (accepted only by
        // instances without a fill), then pad to fill count 7.
        cyc(1'b1, 4'd15, 32'h12345678, 4'hF, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd15);
        idle(5);

        // Reset pulse mid-fill, then user traffic during the new fill.
        do_reset(1);
        cyc(1'b1, 4'd0, 32'h00000001, 4'hF, 1'b1, 4'd0);
        idle(15);

        // Back-to-back readback of the whole array.
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, '0, '0, '0, 1'b1, 4'(a));
        idle(2);

        // Byte enables.
        cyc(1'b1, 4'd3, 32'h11223344, 4'b1111, 1'b0, '0);
        cyc(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);
        cyc(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);

        // Read during write, full and partial byte enables.
        cyc(1'b1, 4'd5, 32'h00000000, 4'b1111, 1'b0, '0);
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd5);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd5);
        cyc(1'b1, 4'd5, 32'h00000000, 4'b1111, 1'b0, '0);
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd5);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd5);
        cyc(1'b1, 4'd6, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd7);

        // Pipelined reads of a ramp, then hold.
        for (int a = 0; a < 4; a++) cyc(1'b1, 4'(a), 32'(a), 4'hF, 1'b0, '0);
        for (int a = 0; a < 4; a++) cyc(1'b0, '0, '0, '0, 1'b1, 4'(a));
        idle(4);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)));
        end
        idle(4);

        for (int i = 0; i < NI; i++) begin
            checks++;
            if (q_head[i] != q_tail[i]) begin
                failures++;
                $display("FAIL drain[%0d] pending=%0d exp=0", i, q_tail[i] - q_head[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_ram_sdp.md
Name: block_ram_sdp

Overview:
- Parametrised simple-dual-port block RAM: one write port and one read port on a single clock, usable in the same cycle.
- Adds per-byte write enables, a selectable read latency (1 or 2) with a `rd_valid` strobe, a selectable read-during-write mode, and an optional hardware fill of every word after reset.
- Drop-in storage for UART-attached buffers and register files where software must see a known initial memory state.

Parameters:
- RAM_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
- RAM_ADDR_BITS, 13, address width; depth = 2**RAM_ADDR_BITS.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = RAM_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, cycles from `rd_en` to data; legal values 1 or 2.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (byte-merged bypass).
- INIT_ON_RESET, 1, 1 = fill all words with INIT_VALUE after reset; 0 = no fill.
- INIT_VALUE, 0, RAM_WIDTH-bit fill pattern.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  write request.
- wr_addr  in  RAM_ADDR_BITS  write address.
- wr_data  in  RAM_WIDTH  write data.
- wr_be  in  NUM_BYTES  byte enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_addr  in  RAM_ADDR_BITS  read address.
- rd_data  out  RAM_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse per completed read.
- init_busy  out  1  high while the fill sequence runs; user accesses are ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data = 0, rd_valid = 0, all latency-pipeline valid bits = 0.
  - init_busy = INIT_ON_RESET.
  - Fill counter = 0; FSM = INIT if INIT_ON_RESET, else IDLE.
  - The memory array is never reset.
- FSM states: INIT, IDLE.
  - INIT: each cycle write INIT_VALUE (all bytes) to address = counter, then counter += 1.
  - When counter = 2**RAM_ADDR_BITS-1 is written, go to IDLE and drop init_busy on the next edge.
  - After rst_n deasserts, init_busy is high for exactly 2**RAM_ADDR_BITS rising edges.
  - IDLE is terminal until the next reset.
- During INIT:
  - wr_en and rd_en are ignored; the memory is unchanged by user writes.
  - No rd_valid is generated.
  - Reads already in the pipeline when reset asserts are discarded.
- Reset asserted mid-INIT: the fill restarts from address 0 after release; no partial-state carry-over.
- Write (IDLE, wr_en = 1):
  - Each byte i with wr_be[i] = 1 is updated at the clock edge; bytes with wr_be[i] = 0 keep their contents.
  - wr_be = 0 is a no-op.
- Read (IDLE, rd_en = 1 at edge T):
  - rd_data shows mem[rd_addr] after edge T+READ_LATENCY-1, and rd_valid is high for that same cycle.
  - READ_LATENCY = 2 adds one output register stage; the array read stays synchronous.
  - Fully pipelined: one read accepted per cycle, results in issue order.
  - rd_data holds its last value when no read completes; rd_valid = 0 in those cycles.
- Same-cycle write and read, same address:
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns, per byte, wr_data where wr_be = 1, otherwise the old byte.
  - Different addresses: independent, no interaction.
- Address wrap: fill counter width is RAM_ADDR_BITS+1 or uses explicit terminal compare; no wrap back into INIT.
- Illegal parameters (READ_LATENCY not 1/2, RAM_WIDTH % BYTE_WIDTH != 0): elaboration-time error.

Test Plan:
Bench config unless stated: RAM_WIDTH = 32, RAM_ADDR_BITS = 4, INIT_VALUE = 32'hA5A5A5A5, INIT_ON_RESET = 1, READ_LATENCY = 1, RDW_MODE = 0.
1. Release rst_n -> init_busy high for exactly 16 edges, then 0; read addresses 0..15 back-to-back -> every rd_data = A5A5A5A5 with rd_valid high 16 consecutive cycles.
2. Write addr 3 = 11223344 with be = 1111; then write addr 3 = AABBCCDD with be = 0101; read addr 3 -> 11BB33DD. Write with be = 0000 -> word unchanged.
3. Addr 5 = 00000000; same cycle write DEADBEEF with be = 1111 and read addr 5:
   - RDW_MODE 0 -> 00000000, then a re-read returns DEADBEEF.
   - RDW_MODE 1 -> DEADBEEF.
   - RDW_MODE 1 with be = 0011 over 00000000 -> 0000BEEF.
4. READ_LATENCY = 2; preload addr 0..3 = 0,1,2,3; rd_en high at edges T..T+3 -> rd_valid high in cycles following edges T+1..T+4, data 0,1,2,3 in order; rd_data holds 3 afterwards with rd_valid = 0.
5. Release reset; at fill count 7 pulse rst_n low for 1 cycle:
   - During reset: outputs are rd_data = 0, rd_valid = 0, init_busy = 1.
   - After release: init_busy high for 16 full edges.
   - wr_en to addr 0 with data 00000001 and rd_en issued during init -> ignored, no rd_valid; later read of addr 0 -> A5A5A5A5.
6. INIT_ON_RESET = 0 -> init_busy = 0 from reset; a write then read of addr 15 in the first cycles after release returns the written data.
